bram_port_arbiter: RTL and testbench

Two-requester arbiter that shares port A of one `true_dpbram` (DWIDTH 32, AWIDTH 12) between a host loader (requester 0) and `data_mover_bram` (requester 1). It grants whole-burst ownership with round-robin fairness and an optional hold limit. It muxes address, control and write data to the BRAM and routes the 1-cycle-latency read data back with a per-requester valid. It sits between the BRAM port A and the two masters, so the TB/host no longer needs a dedicated port B.

---
 rtl/bram_port_arbiter_if.sv | 67 ++++++
 rtl/bram_port_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_bram_port_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// bram_port_arbiter_if
//
// Purpose:
//   Bundles the requester-side and BRAM-side signals of bram_port_arbiter.
//   The arbiter attaches through the slave modport. The bench or the
//   surrounding system attaches through the master modport, which drives
//   the two requesters and the BRAM read data.
//
// Signal summary:
//   req0/req1       requester -> arb   request / hold ownership
//   gnt0/gnt1       arb -> requester   registered grant
//   addr0/addr1     requester -> arb   requester address (AWIDTH)
//   ce0/ce1         requester -> arb   access enable
//   we0/we1         requester -> arb   write enable
//   d0/d1           requester -> arb   write data (DWIDTH)
//   q_o             arb -> requester   shared read data, qualified by rvalid
//   rvalid0/rvalid1 arb -> requester   read data valid per requester
//   addr_b/ce_b/we_b/d_b  arb -> BRAM  port A drive
//   q_b             BRAM -> arb        port A read data (1-cycle latency)
//   o_owner         arb -> system      00 idle, 01 req0, 10 req1
//   o_err           arb -> system      sticky ce-without-grant flag
// -----------------------------------------------------------------------------
interface bram_port_arbiter_if #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 12
);

   logic              req0;
   logic              req1;
   logic              gnt0;
   logic              gnt1;
   logic [AWIDTH-1:0] addr0;
   logic [AWIDTH-1:0] addr1;
   logic              ce0;
   logic              ce1;
   logic              we0;
   logic              we1;
   logic [DWIDTH-1:0] d0;
   logic [DWIDTH-1:0] d1;
   logic [DWIDTH-1:0] q_o;
   logic              rvalid0;
   logic              rvalid1;
   logic [AWIDTH-1:0] addr_b;
   logic              ce_b;
   logic              we_b;
   logic [DWIDTH-1:0] d_b;
   logic [DWIDTH-1:0] q_b;
   logic [1:0]        o_owner;
   logic              o_err;

   // The arbiter's view: requester controls and BRAM read data come in,
   // grants, read responses, BRAM drive and status go out.
   modport slave (
      input  req0, req1, addr0, addr1, ce0, ce1, we0, we1, d0, d1, q_b,
      output gnt0, gnt1, q_o, rvalid0, rvalid1,
      output addr_b, ce_b, we_b, d_b, o_owner, o_err
   );

   // The system's view: it plays both requesters and the BRAM port.
   modport master (
      output req0, req1, addr0, addr1, ce0, ce1, we0, we1, d0, d1, q_b,
      input  gnt0, gnt1, q_o, rvalid0, rvalid1,
      input  addr_b, ce_b, we_b, d_b, o_owner, o_err
   );

endinterface

// File: rtl/bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// bram_port_arbiter
//
// Purpose:
//   Shares port A of a single-clock true dual-port BRAM between two
//   requesters (0 = host loader, 1 = data mover). Ownership is granted for
//   whole bursts with round-robin tie breaking, and an optional hold limit
//   (MAX_HOLD) forces the owner to hand over when the other side has been
//   waiting too long. Address, control and write data of the owner are
//   muxed onto the BRAM; read data (1-cycle latency) is routed back with a
//   valid strobe for whichever requester issued the read.
//
// Parameters:
//   DWIDTH    BRAM data width
//   AWIDTH    BRAM address width
//   MAX_HOLD  cycles an owner may keep the grant while the other side waits
//             (0 = unlimited)
//
// Ports:
//   clk       single clock, rising edge
//   reset     synchronous, active-high
//   bus       bram_port_arbiter_if.slave, requester and BRAM signals
// -----------------------------------------------------------------------------
module bram_port_arbiter #(
   parameter int DWIDTH   = 32,
   parameter int AWIDTH   = 12,
   parameter int MAX_HOLD = 0
) (
   input logic                 clk,
   input logic                 reset,
   bram_port_arbiter_if.slave  bus
);

   // State encoding doubles as the o_owner code.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN0 = 2'b01,
      OWN1 = 2'b10
   } state_t;

   // The hold counter only has to reach MAX_HOLD-1, after which it
   // saturates at all-ones.
   localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
   localparam bit HOLD_EN = (MAX_HOLD != 0);

   state_t          state_q;
   state_t          state_d;
   logic            gnt0_q;
   logic            gnt1_q;
   logic [1:0]      owner_q;
   logic            last_q;
   logic            last_d;
   logic [HW-1:0]   holdCnt_q;
   logic [HW-1:0]   holdCnt_d;

   logic            rdPend_q;
   logic            rdOwner_q;
   logic            err_q;

   logic            ceSel;
   logic            weSel;
   logic [AWIDTH-1:0] addrSel;
   logic [DWIDTH-1:0] dSel;
   logic            forceSwitch;

   // Forced handover only applies while the other requester is actually
   // waiting and the owner has used up its hold budget.
   always_comb begin
      forceSwitch = 1'b0;
      if (HOLD_EN) begin
         if (state_q == OWN0) begin
            forceSwitch = bus.req1 && (holdCnt_q == HOLD_LAST);
         end else if (state_q == OWN1) begin
            forceSwitch = bus.req0 && (holdCnt_q == HOLD_LAST);
         end
      end
   end

   // Next-state logic. A tie from IDLE goes to the requester that did not
   // own the port last. An owner dropping req hands straight over to a
   // waiting requester without passing through IDLE. The hold counter
   // measures how long the other side has been kept waiting; entering a new
   // ownership restarts it.
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      holdCnt_d = holdCnt_q;

      case (state_q)
         IDLE: begin
            if (bus.req0 && !(bus.req1 && !last_q)) begin
               state_d = OWN0;
            end else if (bus.req1) begin
               state_d = OWN1;
            end
         end
         OWN0: begin
            if (!bus.req0) begin
               state_d = bus.req1 ? OWN1 : IDLE;
            end else if (forceSwitch) begin
               state_d = OWN1;
            end else if (bus.req1 && (holdCnt_q != '1)) begin
               holdCnt_d = holdCnt_q + 1'b1;
            end
         end
         OWN1: begin
            if (!bus.req1) begin
               state_d = bus.req0 ? OWN0 : IDLE;
            end else if (forceSwitch) begin
               state_d = OWN0;
            end else if (bus.req0 && (holdCnt_q != '1)) begin
               holdCnt_d = holdCnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if ((state_d == OWN0) && (state_q != OWN0)) begin
         last_d    = 1'b0;
         holdCnt_d = '0;
      end else if ((state_d == OWN1) && (state_q != OWN1)) begin
         last_d    = 1'b1;
         holdCnt_d = '0;
      end
   end

   // Arbitration FSM with registered grant and owner outputs. The grants
   // are decoded from the next state so they line up exactly with state_q.
   // last resets to 1 so requester 0 wins the very first tie.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         owner_q   <= 2'b00;
         last_q    <= 1'b1;
         holdCnt_q <= '0;
      end else begin
         state_q   <= state_d;
         gnt0_q    <= (state_d == OWN0);
         gnt1_q    <= (state_d == OWN1);
         owner_q   <= state_d;
         last_q    <= last_d;
         holdCnt_q <= holdCnt_d;
      end
   end

   // BRAM port drive. Only the granted requester's enable reaches the BRAM;
   // a non-owner's access is simply dropped. With no owner the address and
   // data buses rest at zero.
   always_comb begin
      ceSel   = (gnt0_q & bus.ce0) | (gnt1_q & bus.ce1);
      weSel   = 1'b0;
      addrSel = '0;
      dSel    = '0;
      if (gnt0_q) begin
         weSel   = bus.we0 & ceSel;
         addrSel = bus.addr0;
         dSel    = bus.d0;
      end else if (gnt1_q) begin
         weSel   = bus.we1 & ceSel;
         addrSel = bus.addr1;
         dSel    = bus.d1;
      end
   end

   assign bus.ce_b   = ceSel;
   assign bus.we_b   = weSel;
   assign bus.addr_b = addrSel;
   assign bus.d_b    = dSel;

   // Read tag and error flag. The owner at the time of the read is latched
   // so the response still goes to it even if the grant moves on the same
   // edge. Reset discards any read still in flight. The error flag is
   // sticky: any enable raised without the matching grant sets it.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdPend_q  <= 1'b0;
         rdOwner_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         rdPend_q <= ceSel & ~weSel;
         if (ceSel & ~weSel) begin
            rdOwner_q <= gnt1_q;
         end
         err_q <= err_q | (bus.ce0 & ~gnt0_q) | (bus.ce1 & ~gnt1_q);
      end
   end

   // Read data is only passed through while a response is due, so q_o sits
   // at zero otherwise.
   assign bus.rvalid0 = rdPend_q & ~rdOwner_q;
   assign bus.rvalid1 = rdPend_q & rdOwner_q;
   assign bus.q_o     = rdPend_q ? bus.q_b : '0;

   assign bus.gnt0    = gnt0_q;
   assign bus.gnt1    = gnt1_q;
   assign bus.o_owner = owner_q;
   assign bus.o_err   = err_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bram_port_arbiter
//
// Purpose:
//   Self-checking bench for bram_port_arbiter (MAX_HOLD = 4). The bench plays
//   both requesters and models BRAM port A. Expected read responses are
//   queued with the cycle they are due and checked by a monitor on the
//   falling edge; each scenario task checks grants, BRAM drive and status
//   inline.
// -----------------------------------------------------------------------------
module tb_bram_port_arbiter;

   localparam int DW = 32;
   localparam int AW = 12;
   localparam logic [31:0] BASE = 32'h11223344;

   typedef struct {
      int unsigned due;
      logic        owner;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   int unsigned cycleCount = 0;
   int          checks = 0;
   int          errors = 0;
   exp_t        sbQ[$];
   logic [31:0] mem [0:4095];

   bram_port_arbiter_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

   bram_port_arbiter #(
      .DWIDTH  (DW),
      .AWIDTH  (AW),
      .MAX_HOLD(4)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   // Free-running clock and a cycle counter used to stamp read responses.
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cycleCount <= cycleCount + 1;
   end

   // Behavioural BRAM port A: write-on-ce, registered read.
   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = '0;
      bus.q_b = '0;
   end

   always @(posedge clk) begin
      if (bus.ce_b) begin
         if (bus.we_b) begin
            mem[bus.addr_b] <= bus.d_b;
         end else begin
            bus.q_b <= mem[bus.addr_b];
         end
      end
   end

   // Read-response monitor: a queued response must appear exactly in its
   // due cycle on the right requester with the right data; any rvalid with
   // nothing due is an error.
   always @(negedge clk) begin
      if (sbQ.size() > 0 && sbQ[0].due == cycleCount) begin
         exp_t e;
         e = sbQ.pop_front();
         checks++;
         if ({bus.rvalid1, bus.rvalid0} !== (e.owner ? 2'b10 : 2'b01) || bus.q_o !== e.data) begin
            errors++;
            $display("[TB] FAIL read_resp: got rvalid1/0=%b%b q_o=%h, expected owner=%0d q_o=%h",
                     bus.rvalid1, bus.rvalid0, bus.q_o, e.owner, e.data);
         end
      end else if (bus.rvalid0 === 1'b1 || bus.rvalid1 === 1'b1) begin
         checks++;
         errors++;
         $display("[TB] FAIL spurious_rvalid: got rvalid1/0=%b%b, expected 00", bus.rvalid1, bus.rvalid0);
      end
   end

   // Advance one cycle and settle just after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic r0, input logic r1);
      bus.req0 = r0;
      bus.req1 = r1;
   endtask

   // Reset state of every output.
   task automatic test_reset();
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0);
      bus.ce0 = 0; bus.ce1 = 0; bus.we0 = 0; bus.we1 = 0;
      bus.addr0 = '0; bus.addr1 = '0; bus.d0 = '0; bus.d1 = '0;
      repeat (3) tick();
      checks++;
      if ({bus.gnt1, bus.gnt0, bus.o_owner} !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL reset_grant: got %b, expected 0000", {bus.gnt1, bus.gnt0, bus.o_owner});
      end
      checks++;
      if ({bus.rvalid1, bus.rvalid0, bus.o_err} !== 3'b000 || bus.q_o !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_resp: got rvalid=%b%b err=%b q_o=%h, expected 0",
                  bus.rvalid1, bus.rvalid0, bus.o_err, bus.q_o);
      end
      checks++;
      if ({bus.ce_b, bus.we_b, bus.addr_b, bus.d_b} !== 46'h0) begin
         errors++;
         $display("[TB] FAIL reset_drive: got ce=%b we=%b addr=%h d=%h, expected 0",
                  bus.ce_b, bus.we_b, bus.addr_b, bus.d_b);
      end
      reset = 1'b0;
      tick();
   endtask

   // Requester 0 alone writes addresses 0..7, dropping req on the last write.
   task automatic test_write_burst();
      applyStimulus(1'b1, 1'b0);
      tick();
      checks++;
      if ({bus.gnt1, bus.gnt0, bus.o_owner} !== 4'b0101) begin
         errors++;
         $display("[TB] FAIL wr_grant: got %b, expected 0101", {bus.gnt1, bus.gnt0, bus.o_owner});
      end
      for (int i = 0; i < 8; i++) begin
         bus.ce0 = 1'b1; bus.we0 = 1'b1;
         bus.addr0 = 12'(i); bus.d0 = BASE + 32'(i);
         if (i == 7) bus.req0 = 1'b0;
         #1;
         checks++;
         if ({bus.ce_b, bus.we_b, bus.addr_b, bus.d_b} !== {1'b1, 1'b1, 12'(i), BASE + 32'(i)}) begin
            errors++;
            $display("[TB] FAIL wr_drive[%0d]: got ce=%b we=%b addr=%h d=%h, expected 1 1 %h %h",
                     i, bus.ce_b, bus.we_b, bus.addr_b, bus.d_b, 12'(i), BASE + 32'(i));
         end
         tick();
      end
      bus.ce0 = 1'b0; bus.we0 = 1'b0;
      checks++;
      if ({bus.gnt1, bus.gnt0, bus.o_owner} !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL wr_release: got %b, expected 0000", {bus.gnt1, bus.gnt0, bus.o_owner});
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (mem[i] !== BASE + 32'(i)) begin
            errors++;
            $display("[TB] FAIL wr_mem[%0d]: got %h, expected %h", i, mem[i], BASE + 32'(i));
         end
      end
      checks++;
      if (bus.o_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL wr_err: got %b, expected 0", bus.o_err);
      end
   endtask

   // Requester 1 alone streams reads of 0..7; responses are scoreboarded.
   task automatic test_read_burst();
      exp_t e;
      applyStimulus(1'b0, 1'b1);
      tick();
      checks++;
      if ({bus.gnt1, bus.gnt0, bus.o_owner} !== 4'b1010) begin
         errors++;
         $display("[TB] FAIL rd_grant: got %b, expected 1010", {bus.gnt1, bus.gnt0, bus.o_owner});
      end
      for (int i = 0; i < 8; i++) begin
         bus.ce1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 12'(i);
         if (i == 7) bus.req1 = 1'b0;
         e.due = cycleCount + 1; e.owner = 1'b1; e.data = BASE + 32'(i);
         sbQ.push_back(e);
         tick();
      end
      bus.ce1 = 1'b0;
      repeat (3) tick();
      checks++;
      if (sbQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL rd_drain: got %0d pending, expected 0", sbQ.size());
      end
   endtask

   // Round-robin ties, gap-free handover and simultaneous release/request.
   task automatic test_tie();
      logic [3:0] expSeq [7];
      logic       r0Seq  [7];
      logic       r1Seq  [7];
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0);
      tick();
      reset = 1'b0;
      r0Seq = '{1, 0, 0, 1, 0, 1, 1};
      r1Seq = '{1, 1, 0, 1, 0, 1, 0};
      expSeq = '{4'b0101, 4'b1010, 4'b0000, 4'b0101, 4'b0000, 4'b1010, 4'b0101};
      for (int i = 0; i < 7; i++) begin
         applyStimulus(r0Seq[i], r1Seq[i]);
         tick();
         checks++;
         if ({bus.gnt1, bus.gnt0, bus.o_owner} !== expSeq[i]) begin
            errors++;
            $display("[TB] FAIL tie_step[%0d]: got %b, expected %b",
                     i, {bus.gnt1, bus.gnt0, bus.o_owner}, expSeq[i]);
         end
      end
      applyStimulus(1'b0, 1'b0);
      tick();
   endtask

   // Hold limit of 4: forced switch after 4 waiting cycles, with a read in
   // the last owned cycle still returning to requester 0.
   task automatic test_max_hold();
      exp_t e;
      applyStimulus(1'b1, 1'b0);
      tick();
      bus.req1 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({bus.gnt1, bus.gnt0, bus.o_owner} !== 4'b0101) begin
            errors++;
            $display("[TB] FAIL hold_wait[%0d]: got %b, expected 0101", i, {bus.gnt1, bus.gnt0, bus.o_owner});
         end
      end
      bus.ce0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 12'd3;
      e.due = cycleCount + 1; e.owner = 1'b0; e.data = BASE + 32'd3;
      sbQ.push_back(e);
      tick();
      bus.ce0 = 1'b0; bus.req0 = 1'b0;
      checks++;
      if ({bus.gnt1, bus.gnt0, bus.o_owner} !== 4'b1010) begin
         errors++;
         $display("[TB] FAIL hold_switch: got %b, expected 1010", {bus.gnt1, bus.gnt0, bus.o_owner});
      end
      tick();
      bus.req1 = 1'b0;
      repeat (2) tick();
      checks++;
      if (sbQ.size() != 0 || bus.o_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL hold_drain: got pending=%0d err=%b, expected 0 0", sbQ.size(), bus.o_err);
      end
   endtask

   // Write attempt by requester 1 while requester 0 owns the port.
   task automatic test_err();
      applyStimulus(1'b1, 1'b0);
      tick();
      bus.ce1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 12'd5; bus.d1 = 32'hDEADBEEF;
      #1;
      checks++;
      if (bus.ce_b !== 1'b0) begin
         errors++;
         $display("[TB] FAIL err_dropped: got ce_b=%b, expected 0", bus.ce_b);
      end
      tick();
      bus.ce1 = 1'b0; bus.we1 = 1'b0;
      checks++;
      if (bus.o_err !== 1'b1 || mem[5] !== BASE + 32'd5) begin
         errors++;
         $display("[TB] FAIL err_set: got err=%b mem5=%h, expected 1 %h", bus.o_err, mem[5], BASE + 32'd5);
      end
      bus.req0 = 1'b0;
      repeat (3) tick();
      checks++;
      if (bus.o_err !== 1'b1) begin
         errors++;
         $display("[TB] FAIL err_sticky: got %b, expected 1", bus.o_err);
      end
   endtask

   // Reset one cycle after a read: that read returns, the next one is lost.
   task automatic test_reset_mid_burst();
      exp_t e;
      applyStimulus(1'b0, 1'b1);
      tick();
      bus.ce1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 12'd2;
      e.due = cycleCount + 1; e.owner = 1'b1; e.data = BASE + 32'd2;
      sbQ.push_back(e);
      tick();
      bus.addr1 = 12'd4;
      reset = 1'b1;
      tick();
      checks++;
      if ({bus.gnt1, bus.gnt0, bus.o_owner, bus.o_err} !== 5'b00000) begin
         errors++;
         $display("[TB] FAIL rst_state: got gnt/owner/err=%b, expected 00000",
                  {bus.gnt1, bus.gnt0, bus.o_owner, bus.o_err});
      end
      checks++;
      if ({bus.rvalid1, bus.rvalid0} !== 2'b00 || bus.q_o !== 32'h0) begin
         errors++;
         $display("[TB] FAIL rst_rvalid: got %b%b q_o=%h, expected 00 0", bus.rvalid1, bus.rvalid0, bus.q_o);
      end
      reset = 1'b0;
      bus.ce1 = 1'b0;
      applyStimulus(1'b0, 1'b0);
      repeat (2) tick();
      checks++;
      if (sbQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL rst_drain: got %0d pending, expected 0", sbQ.size());
      end
   endtask

   // Scenario sequence and summary.
   initial begin
      test_reset();
      test_write_burst();
      test_read_burst();
      test_tie();
      test_max_hold();
      test_err();
      test_reset_mid_burst();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
